// File: rtl/zero_run_detector_pkg.sv
// Shared state encoding and default sizing for the zero-run detector.
// Holds no logic; imported by the detector top and its counter.
package zero_run_detector_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam int DEF_W       = 8;
  localparam int DEF_MIN_RUN = 3;
  localparam int CNT_MAX     = (2 ** DEF_W) - 1;

endpackage

// File: rtl/zero_run_counter.sv
// W-bit saturating run counter; clr with inc loads 1, clr alone loads 0.
// Single-cycle update, frozen while i_en is low; o_at_max flags saturation.
module zero_run_counter #(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_at_max
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == {W{1'b1}});

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_cnt <= i_inc ? W'(1) : '0;
      end else if (i_inc && !w_at_max) begin
        r_cnt <= r_cnt + W'(1);
      end
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/zero_run_detector.sv
// Measures runs of ~(x1|x0) samples and reports lengths >= MIN_RUN via valid/ack.
// valid rises on the edge sampling the run's end; it holds until the edge after ack.
module zero_run_detector
  import zero_run_detector_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int MIN_RUN = DEF_MIN_RUN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         x1,
  input  logic         x0,
  input  logic         enable,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] run_len,
  output logic         sat,
  output logic         busy
);

  localparam logic [W-1:0] L_MIN_RUN = W'(MIN_RUN);

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic         w_z;
  logic         w_cnt_clr;
  logic         w_cnt_inc;
  logic         w_load;
  logic [W-1:0] w_cnt;
  logic         w_at_max;
  logic [W-1:0] r_run_len;
  logic         r_sat;

  assign w_z = ~(x1 | x0);

  zero_run_counter #(.W(W)) u_cnt (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_en     (enable),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_cnt_inc),
    .o_cnt    (w_cnt),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Only REPORT reacts while enable is low: ack must still release the report.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_z) begin
          w_state_nxt = S_COUNT;
          w_cnt_clr   = 1'b1;
          w_cnt_inc   = 1'b1;
        end
      end
      S_COUNT: begin
        if (enable) begin
          if (w_z) begin
            w_cnt_inc = 1'b1;
          end else begin
            w_cnt_clr = 1'b1;
            if (w_cnt >= L_MIN_RUN) begin
              w_state_nxt = S_REPORT;
              w_load      = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_REPORT: begin
        if (ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    valid = (r_state == S_REPORT);
    busy  = (r_state == S_COUNT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_run_len <= '0;
      r_sat     <= 1'b0;
    end else if (w_load) begin
      r_run_len <= w_cnt;
      r_sat     <= w_at_max;
    end
  end

  assign run_len = r_run_len;
  assign sat     = r_sat;

endmodule

// File: tb/tb_zero_run_detector.sv
// Drives W=8 and W=4 detectors with shared stimulus; expected reports are queued
// as runs are driven and popped when each detector raises valid.
module tb_zero_run_detector;

  logic       clock = 1'b0;
  logic       reset;
  logic       x1;
  logic       x0;
  logic       enable;
  logic       ack;
  logic       valid8, sat8, busy8;
  logic [7:0] run_len8;
  logic       valid4, sat4, busy4;
  logic [3:0] run_len4;

  int n_vec = 0;
  int n_err = 0;
  int exp8_q[$];
  int exp4_q[$];
  int e8, e4;
  logic pv8 = 1'b0;
  logic pv4 = 1'b0;

  always #5 clock = ~clock;

  zero_run_detector #(.W(8), .MIN_RUN(3)) dut8 (
    .clock(clock), .reset(reset), .x1(x1), .x0(x0), .enable(enable), .ack(ack),
    .valid(valid8), .run_len(run_len8), .sat(sat8), .busy(busy8)
  );

  zero_run_detector #(.W(4), .MIN_RUN(3)) dut4 (
    .clock(clock), .reset(reset), .x1(x1), .x0(x0), .enable(enable), .ack(ack),
    .valid(valid4), .run_len(run_len4), .sat(sat4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] x, input logic en, input logic a);
    {x1, x0} = x;
    enable   = en;
    ack      = a;
    @(posedge clock);
    #1;
  endtask

  task automatic push_both(input int len8, input int sat8_e, input int len4, input int sat4_e);
    exp8_q.push_back(len8 | (sat8_e << 16));
    exp4_q.push_back(len4 | (sat4_e << 16));
  endtask

  // Scoreboard: every rising valid must match the oldest queued expectation.
  always @(negedge clock) begin
    if (valid8 === 1'b1 && pv8 !== 1'b1) begin
      if (exp8_q.size() == 0) begin
        chk("w8_unexpected_report", 1, 0);
      end else begin
        e8 = exp8_q.pop_front();
        chk("w8_run_len", 32'(run_len8), 32'(e8 & 'hffff));
        chk("w8_sat", 32'(sat8), 32'(e8 >> 16));
      end
    end
    if (valid4 === 1'b1 && pv4 !== 1'b1) begin
      if (exp4_q.size() == 0) begin
        chk("w4_unexpected_report", 1, 0);
      end else begin
        e4 = exp4_q.pop_front();
        chk("w4_run_len", 32'(run_len4), 32'(e4 & 'hffff));
        chk("w4_sat", 32'(sat4), 32'(e4 >> 16));
      end
    end
    pv8 = valid8;
    pv4 = valid4;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b8;
    int b4;
    reset  = 1'b1;
    {x1, x0} = 2'b11;
    enable = 1'b0;
    ack    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_valid8", 32'(valid8), 0);
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_run_len8", 32'(run_len8), 0);
    chk("rst_sat8", 32'(sat8), 0);
    chk("rst_valid4", 32'(valid4), 0);
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_run_len4", 32'(run_len4), 0);
    chk("rst_sat4", 32'(sat4), 0);

    // Five-sample run, report held while ack stays low.
    repeat (5) step(2'b00, 1'b1, 1'b0);
    push_both(5, 0, 5, 0);
    step(2'b01, 1'b1, 1'b0);
    chk("run5_valid_now", 32'(valid8), 1);
    repeat (6) step(2'b01, 1'b1, 1'b0);
    chk("run5_valid_held8", 32'(valid8), 1);
    chk("run5_valid_held4", 32'(valid4), 1);
    chk("run5_len_held", 32'(run_len8), 5);
    step(2'b01, 1'b1, 1'b1);
    chk("run5_ack_valid8", 32'(valid8), 0);
    chk("run5_ack_valid4", 32'(valid4), 0);
    chk("run5_len_kept", 32'(run_len8), 5);

    // Two-sample glitch is filtered.
    b8 = 0;
    b4 = 0;
    repeat (2) begin
      step(2'b00, 1'b1, 1'b0);
      b8 += int'(busy8);
      b4 += int'(busy4);
    end
    repeat (4) begin
      step(2'b10, 1'b1, 1'b0);
      b8 += int'(busy8);
      b4 += int'(busy4);
    end
    chk("glitch_busy_cycles8", 32'(b8), 2);
    chk("glitch_busy_cycles4", 32'(b4), 2);
    chk("glitch_no_valid", 32'(valid8), 0);

    // Twenty-sample run saturates the 4-bit counter only.
    repeat (20) step(2'b00, 1'b1, 1'b0);
    push_both(20, 0, 15, 1);
    step(2'b11, 1'b1, 1'b0);
    chk("long_valid8", 32'(valid8), 1);
    chk("long_valid4", 32'(valid4), 1);
    step(2'b11, 1'b1, 1'b1);
    chk("long_ack_valid8", 32'(valid8), 0);
    chk("long_ack_valid4", 32'(valid4), 0);

    // Enable gap inside a four-sample run; z during REPORT is ignored.
    repeat (2) step(2'b00, 1'b1, 1'b0);
    repeat (3) step(2'b11, 1'b0, 1'b0);
    chk("freeze_busy8", 32'(busy8), 1);
    repeat (2) step(2'b00, 1'b1, 1'b0);
    push_both(4, 0, 4, 0);
    step(2'b01, 1'b1, 1'b0);
    repeat (4) step(2'b00, 1'b1, 1'b0);
    chk("report_hold_valid", 32'(valid8), 1);
    chk("report_hold_len8", 32'(run_len8), 4);
    chk("report_hold_len4", 32'(run_len4), 4);
    step(2'b00, 1'b1, 1'b1);
    chk("ack_edge_not_counted", 32'(busy8), 0);
    chk("ack_edge_valid", 32'(valid8), 0);
    repeat (3) step(2'b01, 1'b1, 1'b0);
    chk("after_ack_idle", 32'(busy8), 0);

    // Reset during COUNT.
    repeat (6) step(2'b00, 1'b1, 1'b0);
    chk("cnt6_busy", 32'(busy8), 1);
    reset = 1'b1;
    step(2'b00, 1'b1, 1'b0);
    reset = 1'b0;
    chk("rst_count_valid", 32'(valid8), 0);
    chk("rst_count_busy", 32'(busy8), 0);
    step(2'b01, 1'b1, 1'b0);

    // Reset during REPORT.
    repeat (3) step(2'b00, 1'b1, 1'b0);
    push_both(3, 0, 3, 0);
    step(2'b01, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(valid8), 1);
    reset = 1'b1;
    step(2'b01, 1'b1, 1'b0);
    reset = 1'b0;
    chk("rst_report_valid", 32'(valid8), 0);
    chk("rst_report_busy", 32'(busy8), 0);
    chk("rst_report_len", 32'(run_len8), 0);

    // Minimum-length run after reset is reported.
    repeat (3) step(2'b00, 1'b1, 1'b0);
    push_both(3, 0, 3, 0);
    step(2'b01, 1'b1, 1'b0);
    chk("min_run_valid", 32'(valid8), 1);
    step(2'b01, 1'b1, 1'b1);
    chk("min_run_ack", 32'(valid8), 0);

    repeat (2) step(2'b01, 1'b1, 1'b0);
    chk("w8_pending_reports", 32'(exp8_q.size()), 0);
    chk("w4_pending_reports", 32'(exp4_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
